// File: rtl/apb_master_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_arb_pkg
//  Description : Shared types and defaults for the multi-requester APB
//                master: FSM state encoding, default bus widths and the
//                timeout counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_master_arb_pkg;

    // APB transfer phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int c_ADDR_W_DEF = 8;
    localparam int c_DATA_W_DEF = 32;

    // The counter must be able to hold TIMEOUT itself. A disabled timeout
    // (0) still gets a one-bit counter so no zero-width vector appears.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_arb_if
//  Description : APB bus bundle between the arbitrating master and the slave.
//                master modport : drives psel/penable/pwrite/paddr/pwdata,
//                                 receives pready/read_data
//                slave modport  : the mirror image
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_arb_if
    import apb_master_arb_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int DATA_W = c_DATA_W_DEF
) ();

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] read_data;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, read_data
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, read_data
    );

endinterface
`default_nettype wire

// File: rtl/apb_master_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rr_arbiter
//  Description : Round-robin grant selection. The grant is the first
//                eligible index strictly after the pointer, wrapping.
//                The pointer moves to the granted index on i_grant_en.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                i_eligible      - per-requester eligibility
//                i_grant_en      - commit the current grant to the pointer
//                o_grant_idx     - selected requester index
//                o_grant_valid   - at least one requester is eligible
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [N_REQ-1:0] i_eligible,
    input  wire logic             i_grant_en,
    output logic      [IDX_W-1:0] o_grant_idx,
    output logic                  o_grant_valid
);

    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W:0]   w_cand;

    // Scan from the farthest candidate to the nearest so the nearest
    // eligible index after the pointer is the one left standing.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_cand        = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(N_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(N_REQ);
            end
            if (i_eligible[w_cand[IDX_W-1:0]]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

    // Pointer starts at the last index so index 0 wins first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= IDX_W'(N_REQ - 1);
        end else if (i_grant_en && o_grant_valid) begin
            r_rr_ptr <= o_grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_arb
//  Description : APB master shared by N_REQ local requesters. Round-robin
//                arbitration, SETUP->ACCESS sequencing, wait states, read
//                data return and an optional ACCESS-phase timeout.
//  Ports       : pclk, preset    - bus clock, asynchronous active-low reset
//                req/req_write/req_addr/req_wdata - packed requester inputs
//                req_done        - one-cycle completion pulse per requester
//                req_err         - 1 = transfer aborted by timeout
//                req_rdata       - read data, valid with req_done on reads
//                apb             - APB bus (master modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arb
    import apb_master_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = c_ADDR_W_DEF,
    parameter int DATA_W  = c_DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  wire logic                      pclk,
    input  wire logic                      preset,
    input  wire logic [N_REQ-1:0]          req,
    input  wire logic [N_REQ-1:0]          req_write,
    input  wire logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  wire logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic      [N_REQ-1:0]          req_done,
    output logic                           req_err,
    output logic      [DATA_W-1:0]         req_rdata,
    apb_master_arb_if.master               apb
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W:0] c_TMO_LIM = (CNT_W+1)'(TIMEOUT);

    apb_state_e        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_grant, w_grant_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CNT_W:0]    w_cnt_inc;
    logic              w_timeout;

    logic              r_psel, w_psel;
    logic              r_penable, w_penable;
    logic              r_pwrite, w_pwrite;
    logic [ADDR_W-1:0] r_paddr, w_paddr;
    logic [DATA_W-1:0] r_pwdata, w_pwdata;
    logic [N_REQ-1:0]  r_req_done, w_req_done;
    logic              r_req_err, w_req_err;
    logic [DATA_W-1:0] r_req_rdata, w_req_rdata;

    logic [N_REQ-1:0]  w_eligible;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_grant_valid;
    logic              w_grant_en;

    logic [ADDR_W-1:0] w_addr_arr  [N_REQ];
    logic [DATA_W-1:0] w_wdata_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // A requester whose done pulse is on the outputs is still holding req
    // this cycle; masking it prevents a duplicate transfer.
    assign w_eligible = req & ~r_req_done;
    assign w_grant_en = (r_state == IDLE);

    apb_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk           (pclk),
        .rst_n         (preset),
        .i_eligible    (w_eligible),
        .i_grant_en    (w_grant_en),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // The counter value after this ACCESS cycle; reaching the limit with
    // pready still low aborts the transfer.
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == c_TMO_LIM);

    // State and output registers.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_req_done  <= '0;
            r_req_err   <= 1'b0;
            r_req_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_cnt       <= w_cnt_nxt;
            r_psel      <= w_psel;
            r_penable   <= w_penable;
            r_pwrite    <= w_pwrite;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_req_done  <= w_req_done;
            r_req_err   <= w_req_err;
            r_req_rdata <= w_req_rdata;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (apb.pready || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_psel      = r_psel;
        w_penable   = r_penable;
        w_pwrite    = r_pwrite;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;
        w_req_done  = '0;
        w_req_err   = r_req_err;
        w_req_rdata = r_req_rdata;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_grant_nxt = w_grant_idx;
                    w_psel      = 1'b1;
                    w_penable   = 1'b0;
                    w_pwrite    = req_write[w_grant_idx];
                    w_paddr     = w_addr_arr[w_grant_idx];
                    w_pwdata    = w_wdata_arr[w_grant_idx];
                end
            end
            SETUP: begin
                w_penable = 1'b1;
                w_cnt_nxt = '0;
            end
            ACCESS: begin
                if (apb.pready) begin
                    w_psel              = 1'b0;
                    w_penable           = 1'b0;
                    w_req_done[r_grant] = 1'b1;
                    w_req_err           = 1'b0;
                    if (!r_pwrite) w_req_rdata = apb.read_data;
                end else if (w_timeout) begin
                    w_psel              = 1'b0;
                    w_penable           = 1'b0;
                    w_req_done[r_grant] = 1'b1;
                    w_req_err           = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                w_psel    = 1'b0;
                w_penable = 1'b0;
            end
        endcase
    end

    assign apb.psel    = r_psel;
    assign apb.penable = r_penable;
    assign apb.pwrite  = r_pwrite;
    assign apb.paddr   = r_paddr;
    assign apb.pwdata  = r_pwdata;
    assign req_done    = r_req_done;
    assign req_err     = r_req_err;
    assign req_rdata   = r_req_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_arb
//  Description : Self-checking bench for apb_master_arb. A stimulus process
//                issues requests and pushes expected completions into
//                per-requester queues; a slave process answers the bus with
//                chosen wait states; a monitor predicts grants from the
//                rotation rule and pops/compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arb;
    import apb_master_arb_pkg::*;

    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                      pclk = 1'b0;
    logic                      preset = 1'b0;
    logic [N_REQ-1:0]          req;
    logic [N_REQ-1:0]          req_write;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ*DATA_W-1:0]   req_wdata;
    logic [N_REQ-1:0]          req_done;
    logic                      req_err;
    logic [DATA_W-1:0]         req_rdata;

    apb_master_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    apb_master_arb #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .apb       (apb)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                wt;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t              exp_q [N_REQ][$];
    int                wait_of [N_REQ];
    logic [DATA_W-1:0] ref_mem [256];
    logic [DATA_W-1:0] slv_mem [256];
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Requester i owns addresses with addr[7:6] == i, so each requester's
    // read results depend only on its own earlier writes.
    task automatic issue(input int i, input logic wr, input logic [5:0] lo,
                         input logic [DATA_W-1:0] wd, input int wt);
        exp_t e;
        logic [1:0] id;
        id      = i[1:0];
        e.wr    = wr;
        e.addr  = {id, lo};
        e.wdata = wd;
        e.wt    = wt;
        e.err   = (wt >= TIMEOUT);
        e.rdata = ref_mem[e.addr];
        if (wr && !e.err) ref_mem[e.addr] = wd;
        exp_q[i].push_back(e);
        wait_of[i] = wt;
        req_write[i] = wr;
        req_addr[i*ADDR_W +: ADDR_W] = e.addr;
        req_wdata[i*DATA_W +: DATA_W] = wd;
        req[i] = 1'b1;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (req != '0 && n < limit) begin
            @(negedge pclk);
            for (int i = 0; i < N_REQ; i++) if (req[i] && req_done[i]) req[i] = 1'b0;
            n++;
        end
        if (req != '0) fail("drain_timeout");
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 12) return 0;
        if (r < 16) return $urandom_range(1, 3);
        if (r < 18) return 5;
        return TIMEOUT;
    endfunction

    // ---------------- slave -------------------------------------------------
    initial begin : p_slave
        int scnt;
        logic [1:0] id;
        scnt = 0;
        apb.pready = 1'b0;
        apb.read_data = '0;
        forever begin
            @(negedge pclk);
            if (preset && apb.psel && apb.penable) begin
                id = apb.paddr[7:6];
                if (wait_of[id] < TIMEOUT && scnt == wait_of[id]) begin
                    apb.pready = 1'b1;
                    if (apb.pwrite) slv_mem[apb.paddr] = apb.pwdata;
                    else apb.read_data = slv_mem[apb.paddr];
                end else begin
                    apb.pready = 1'b0;
                    apb.read_data = $urandom;
                end
                scnt++;
            end else begin
                scnt = 0;
                apb.pready = 1'($urandom_range(0, 1));
                apb.read_data = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard -----------------------------------
    initial begin : p_mon
        int last_g, cur_g, acc, g, k, idx;
        logic [N_REQ-1:0] mask, elig;
        logic prev_setup;
        logic [ADDR_W-1:0] cap_a;
        logic cap_w;
        logic [DATA_W-1:0] cap_d, prev_rdata;
        exp_t e;
        last_g = N_REQ - 1; cur_g = 0; acc = 0; mask = '0; prev_setup = 1'b0;
        cap_a = '0; cap_w = 1'b0; cap_d = '0; prev_rdata = '0;
        forever begin
            @(posedge pclk); #1;
            if (!preset) begin
                chk("rst_bus_idle", 64'({apb.psel, apb.penable}), 64'(0));
                chk("rst_no_done", 64'(req_done), 64'(0));
                last_g = N_REQ - 1; mask = '0; prev_setup = 1'b0; acc = 0;
            end else begin
                if (prev_setup) chk("setup_one_cycle", 64'(apb.penable), 64'(1));
                if (apb.psel && !apb.penable) begin
                    elig = req & ~mask;
                    g = -1;
                    for (int s = 1; s <= N_REQ; s++) begin
                        idx = (last_g + s) % N_REQ;
                        if (g < 0 && elig[idx[1:0]]) g = idx;
                    end
                    if (g < 0) fail("grant_without_request");
                    else begin
                        chk("grant_id", 64'(apb.paddr[7:6]), 64'(g));
                        if (exp_q[g].size() == 0) fail("grant_no_expectation");
                        else chk("setup_payload", 64'({apb.paddr, apb.pwrite, apb.pwdata}),
                                 64'({exp_q[g][0].addr, exp_q[g][0].wr, exp_q[g][0].wdata}));
                        last_g = g;
                        cur_g = g;
                    end
                    acc = 0;
                    cap_a = apb.paddr; cap_w = apb.pwrite; cap_d = apb.pwdata;
                end
                prev_setup = apb.psel && !apb.penable;
                if (apb.psel && apb.penable) begin
                    acc++;
                    chk("bus_stable", 64'({apb.paddr, apb.pwrite, apb.pwdata}), 64'({cap_a, cap_w, cap_d}));
                end
                mask = '0;
                if (req_done != '0) begin
                    chk("done_onehot", 64'($onehot(req_done)), 64'(1));
                    k = 0;
                    for (int s = 0; s < N_REQ; s++) if (req_done[s]) k = s;
                    chk("done_id", 64'(k), 64'(cur_g));
                    chk("bus_idle_at_done", 64'({apb.psel, apb.penable}), 64'(0));
                    if (exp_q[k].size() == 0) fail("done_unexpected");
                    else begin
                        e = exp_q[k].pop_front();
                        chk("done_err", 64'(req_err), 64'(e.err));
                        if (e.err) chk("timeout_cycles", 64'(acc), 64'(TIMEOUT));
                        else chk("access_cycles", 64'(acc), 64'(e.wt + 1));
                        if (!e.wr && !e.err) chk("read_data", 64'(req_rdata), 64'(e.rdata));
                        else chk("rdata_hold", 64'(req_rdata), 64'(prev_rdata));
                    end
                    mask[k[1:0]] = 1'b1;
                end
            end
            prev_rdata = req_rdata;
        end
    end

    // ---------------- stimulus ----------------------------------------------
    initial begin : p_main
        int remaining [N_REQ];
        int gap [N_REQ];
        int cyc, n;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            ref_mem[i] = {24'hA5C300, a};
            slv_mem[i] = {24'hA5C300, a};
        end
        for (int i = 0; i < N_REQ; i++) wait_of[i] = 0;
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;

        repeat (2) @(posedge pclk);
        #1;
        chk("rst_psel", 64'(apb.psel), 64'(0));
        chk("rst_penable", 64'(apb.penable), 64'(0));
        chk("rst_pwrite", 64'(apb.pwrite), 64'(0));
        chk("rst_paddr", 64'(apb.paddr), 64'(0));
        chk("rst_pwdata", 64'(apb.pwdata), 64'(0));
        chk("rst_req_done", 64'(req_done), 64'(0));
        chk("rst_req_err", 64'(req_err), 64'(0));
        chk("rst_req_rdata", 64'(req_rdata), 64'(0));
        @(negedge pclk);
        preset = 1'b1;

        // Single write with zero wait states, then read it back.
        @(negedge pclk);
        issue(0, 1'b1, 6'h10, 32'hDEADBEEF, 0);
        @(posedge pclk); #1;
        chk("lat_psel", 64'({apb.psel, apb.penable}), 64'(2'b10));
        @(posedge pclk); #1;
        chk("lat_penable", 64'({apb.psel, apb.penable}), 64'(2'b11));
        @(posedge pclk); #1;
        chk("lat_done", 64'({req_done, req_err}), 64'({4'b0001, 1'b0}));
        @(negedge pclk);
        req[0] = 1'b0;
        issue(0, 1'b0, 6'h10, $urandom, 2);
        drain(100);

        // Randomized traffic from all requesters.
        for (int i = 0; i < N_REQ; i++) begin remaining[i] = 25; gap[i] = 0; end
        cyc = 0;
        while (cyc < 8000) begin
            n = 0;
            for (int i = 0; i < N_REQ; i++) n += remaining[i];
            if (n == 0 && req == '0) break;
            @(negedge pclk);
            cyc++;
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && req_done[i]) begin
                    req[i] = 1'b0;
                    gap[i] = $urandom_range(0, 3);
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] && remaining[i] > 0) begin
                    if (gap[i] > 0) gap[i]--;
                    else begin
                        issue(i, 1'($urandom_range(0, 1)), 6'($urandom), $urandom, rand_wait());
                        remaining[i]--;
                    end
                end
            end
        end
        if (cyc >= 8000) fail("random_phase_timeout");

        // Asynchronous reset in the middle of an ACCESS phase.
        @(negedge pclk);
        issue(1, 1'b0, 6'h05, 32'h0, TIMEOUT);
        n = 0;
        while (!(apb.psel && apb.penable) && n < 20) begin @(posedge pclk); #1; n++; end
        if (!(apb.psel && apb.penable)) fail("reach_access_timeout");
        @(negedge pclk);
        issue(2, 1'b1, 6'h22, 32'h12345678, 0);
        issue(3, 1'b0, 6'h01, 32'h0, 1);
        #2 preset = 1'b0;
        #1;
        chk("async_rst_bus", 64'({apb.psel, apb.penable}), 64'(0));
        chk("async_rst_done", 64'(req_done), 64'(0));
        req[1] = 1'b0;
        exp_q[1].delete();
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        preset = 1'b1;
        drain(100);
        @(negedge pclk);
        issue(2, 1'b0, 6'h22, 32'h0, 0);
        drain(100);

        repeat (3) @(negedge pclk);
        for (int i = 0; i < N_REQ; i++) chk("queue_empty", 64'(exp_q[i].size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
